// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter slice.
// Provides the port-source encoding used for tags and owner, the default
// outstanding-transaction depth, the packed request bundle and the lock
// state type used by the top-level FSM.
package sram_like_arbiter_pkg;

   // Source encoding for the FIFO tags and the lock owner.
   localparam logic SRC_INST = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   // Default number of accepted-but-unanswered transactions.
   localparam int DEFAULT_MAX_OUT = 4;

   // Widths of the sram-like request fields.
   localparam int WR_W   = 1;
   localparam int SIZE_W = 2;
   localparam int STRB_W = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int REQ_W  = WR_W + SIZE_W + STRB_W + ADDR_W + DATA_W;

   // Everything that travels downstream with a request, in one bundle.
   typedef struct packed {
      logic              wr;
      logic [SIZE_W-1:0] size;
      logic [STRB_W-1:0] wstrb;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Lock FSM: IDLE picks a winner freely, HOLD pins the downstream request.
   typedef enum logic {
      LOCK_IDLE = 1'b0,
      LOCK_HOLD = 1'b1
   } lock_state_t;

endpackage

// File: rtl/sram_like_arbiter_tag_fifo.sv
// Tag FIFO recording which port issued each accepted transaction, so that
// in-order responses can be steered back to the right port.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   push, push_tag   write one tag (ignored while full)
//   pop              retire the head tag (ignored while empty)
//   full, empty      occupancy flags
//   head             tag at the read pointer
//   count            number of tags stored (0..DEPTH)
module tag_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic                   push_tag,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic                   head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   logic [DEPTH-1:0] tags;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign head    = tags[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two. A push and a
   // pop in the same cycle advance both pointers and leave count unchanged.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tags   <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            tags[wr_ptr] <= push_tag;
            wr_ptr       <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the core's instruction and data
// ports. Picks a requester, keeps the chosen request stable downstream until
// it is accepted, and steers in-order responses back to the issuing port.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_* / data_*             upstream sram-like request/response ports
//   m_*                         shared downstream sram-like port
//   resp_err                    sticky: a response arrived with nothing outstanding
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int MAX_OUT    = DEFAULT_MAX_OUT,
   parameter bit DATA_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata,
   output logic        resp_err
);

   req_t        inst_bundle;
   req_t        data_bundle;
   req_t        sel_bundle;
   lock_state_t lock_state;
   logic        owner;
   logic        sel;
   logic        sel_req;
   logic        acc;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_head;
   logic        resp_valid;
   logic [$clog2(MAX_OUT):0] fifo_count;

   assign inst_bundle = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
   assign data_bundle = {data_wr, data_size, data_wstrb, data_addr, data_wdata};

   // While locked the owner keeps the port; otherwise the sole requester
   // wins, and a tie goes to the DATA_FIRST choice.
   always_comb begin
      sel = SRC_INST;
      if (lock_state == LOCK_HOLD) begin
         sel = owner;
      end else if (inst_req && data_req) begin
         sel = DATA_FIRST ? SRC_DATA : SRC_INST;
      end else if (data_req) begin
         sel = SRC_DATA;
      end else begin
         sel = SRC_INST;
      end
   end

   assign sel_req    = (sel == SRC_DATA) ? data_req : inst_req;
   assign sel_bundle = (sel == SRC_DATA) ? data_bundle : inst_bundle;

   // resetn gates the combinational handshakes so nothing leaks out while
   // the block is held in reset.
   assign m_req   = sel_req & ~fifo_full & resetn;
   assign acc     = m_req & m_addr_ok;
   assign m_wr    = sel_bundle.wr;
   assign m_size  = sel_bundle.size;
   assign m_wstrb = sel_bundle.wstrb;
   assign m_addr  = sel_bundle.addr;
   assign m_wdata = sel_bundle.wdata;

   assign inst_addr_ok = acc & (sel == SRC_INST);
   assign data_addr_ok = acc & (sel == SRC_DATA);

   // Responses are matched against the tag recorded at the time of accept;
   // a tag pushed this same cycle is not visible yet, so an empty FIFO
   // never claims a response.
   assign resp_valid   = m_data_ok & (fifo_count != '0) & resetn;
   assign inst_data_ok = resp_valid & (fifo_head == SRC_INST);
   assign data_data_ok = resp_valid & (fifo_head == SRC_DATA);
   assign inst_rdata   = m_rdata;
   assign data_rdata   = m_rdata;

   // Lock FSM: once a request is shown downstream and not taken, pin the
   // selection on its owner until it is accepted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_state <= LOCK_IDLE;
         owner      <= SRC_INST;
      end else begin
         case (lock_state)
            LOCK_IDLE: begin
               if (m_req && !m_addr_ok) begin
                  lock_state <= LOCK_HOLD;
                  owner      <= sel;
               end
            end
            LOCK_HOLD: begin
               if (acc) begin
                  lock_state <= LOCK_IDLE;
               end
            end
            default: lock_state <= LOCK_IDLE;
         endcase
      end
   end

   // Sticky error for a response that has no transaction to belong to.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resp_err <= 1'b0;
      end else if (m_data_ok && fifo_empty) begin
         resp_err <= 1'b1;
      end
   end

   tag_fifo #(
      .DEPTH (MAX_OUT)
   ) u_tag_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push     (acc),
      .push_tag (sel),
      .pop      (m_data_ok),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios followed by
// a randomized phase. A transaction-level model decides which request the
// shared port should show and which responses belong to which port; a
// separate monitor pops the expected-response queue on every data_ok.
module tb_sram_like_arbiter;

   localparam int MAX_OUT    = 4;
   localparam bit DATA_FIRST = 1'b1;

   logic        clk;
   logic        resetn;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [3:0]  inst_wstrb;
   logic [31:0] inst_addr;
   logic [31:0] inst_wdata;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        m_req;
   logic        m_wr;
   logic [1:0]  m_size;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_addr_ok;
   logic        m_data_ok;
   logic [31:0] m_rdata;
   logic        resp_err;

   typedef struct {
      logic        port;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_q[$];
   int          checks = 0;
   int          passes = 0;
   bit          mon_en = 1'b0;
   bit          held_valid = 1'b0;
   logic        held_port = 1'b0;
   bit          inst_done = 1'b0;
   bit          data_done = 1'b0;

   sram_like_arbiter #(
      .MAX_OUT    (MAX_OUT),
      .DATA_FIRST (DATA_FIRST)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_size    (inst_size),
      .inst_wstrb   (inst_wstrb),
      .inst_addr    (inst_addr),
      .inst_wdata   (inst_wdata),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .m_req        (m_req),
      .m_wr         (m_wr),
      .m_size       (m_size),
      .m_wstrb      (m_wstrb),
      .m_addr       (m_addr),
      .m_wdata      (m_wdata),
      .m_addr_ok    (m_addr_ok),
      .m_data_ok    (m_data_ok),
      .m_rdata      (m_rdata),
      .resp_err     (resp_err)
   );

   // 10 ns clock; inputs change on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One directed cycle: drive on the falling edge, settle, leave the caller
   // just before the next rising edge to sample.
   task automatic apply_stimulus(input logic ireq, input logic dreq, input logic aok,
                                 input logic dok, input logic [31:0] rdata);
      @(negedge clk);
      inst_req  = ireq;
      data_req  = dreq;
      m_addr_ok = aok;
      m_data_ok = dok;
      m_rdata   = rdata;
      #4;
   endtask

   // One randomized cycle: the bench plays both upstream ports and the
   // memory. The model says which request the shared port must show: a
   // request already shown and not taken stays; otherwise a lone requester,
   // or the preferred one on a tie; nothing at all while MAX_OUT are in flight.
   task automatic run_random_cycle(input int p_req, input int p_resp);
      logic        exp_req;
      logic        exp_port;
      logic        any_req;
      logic [31:0] rd;
      bit          is_full;
      @(negedge clk);
      if (inst_done) begin inst_req = 1'b0; inst_done = 1'b0; end
      if (data_done) begin data_req = 1'b0; data_done = 1'b0; end
      if (!inst_req && ($urandom_range(0, 99) < p_req)) begin
         inst_req   = 1'b1;
         inst_wr    = 1'b0;
         inst_size  = 2'd2;
         inst_wstrb = 4'hF;
         inst_addr  = $urandom & 32'hFFFF_FFFC;
         inst_wdata = $urandom;
      end
      if (!data_req && ($urandom_range(0, 99) < p_req)) begin
         data_req   = 1'b1;
         data_wr    = 1'($urandom_range(0, 1));
         data_size  = 2'($urandom_range(0, 2));
         data_wstrb = 4'($urandom);
         data_addr  = $urandom;
         data_wdata = $urandom;
      end
      m_addr_ok = ($urandom_range(0, 99) < 60);
      if (mem_q.size() > 0 && ($urandom_range(0, 99) < p_resp)) begin
         m_data_ok = 1'b1;
         m_rdata   = mem_q[0];
      end else begin
         m_data_ok = 1'b0;
         m_rdata   = $urandom;
      end
      #4;
      is_full = (mem_q.size() >= MAX_OUT);
      any_req = 1'b1;
      if (held_valid)               exp_port = held_port;
      else if (inst_req && data_req) exp_port = DATA_FIRST;
      else if (data_req)             exp_port = 1'b1;
      else if (inst_req)             exp_port = 1'b0;
      else begin exp_port = 1'b0; any_req = 1'b0; end
      exp_req = any_req && !is_full;
      check_output("m_req", 32'(m_req), 32'(exp_req));
      if (exp_req) begin
         check_output("m_addr",  m_addr,  exp_port ? data_addr  : inst_addr);
         check_output("m_wdata", m_wdata, exp_port ? data_wdata : inst_wdata);
         check_output("m_ctrl",  32'({m_wr, m_size, m_wstrb}),
                      exp_port ? 32'({data_wr, data_size, data_wstrb})
                               : 32'({inst_wr, inst_size, inst_wstrb}));
      end
      check_output("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_req && m_addr_ok && !exp_port));
      check_output("data_addr_ok", 32'(data_addr_ok), 32'(exp_req && m_addr_ok && exp_port));
      if (m_data_ok) void'(mem_q.pop_front());
      if (exp_req && m_addr_ok) begin
         rd = $urandom;
         mem_q.push_back(rd);
         exp_q.push_back('{port: exp_port, rdata: rd});
         held_valid = 1'b0;
         if (exp_port) data_done = 1'b1;
         else          inst_done = 1'b1;
      end else if (exp_req) begin
         held_valid = 1'b1;
         held_port  = exp_port;
      end
   endtask

   // Monitor: every response the DUT presents must match the oldest
   // outstanding expectation, and every memory response must be claimed.
   always begin
      exp_t e;
      @(negedge clk);
      #3;
      if (mon_en) begin
         if (inst_data_ok || data_data_ok) begin
            if (exp_q.size() == 0) begin
               check_output("resp_unexpected", 32'({inst_data_ok, data_data_ok}), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_output("resp_onehot", 32'(inst_data_ok & data_data_ok), 32'd0);
               check_output("resp_port", 32'(data_data_ok), 32'(e.port));
               check_output("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
            end
         end else if (m_data_ok) begin
            check_output("resp_dropped", 32'd0, 32'd1);
         end
      end
   end

   initial begin
      int guard;
      resetn     = 1'b0;
      inst_req   = 1'b1;
      inst_wr    = 1'b0;
      inst_size  = 2'd2;
      inst_wstrb = 4'hF;
      inst_addr  = 32'h0;
      inst_wdata = 32'h0;
      data_req   = 1'b1;
      data_wr    = 1'b0;
      data_size  = 2'd2;
      data_wstrb = 4'hF;
      data_addr  = 32'h0;
      data_wdata = 32'h0;
      m_addr_ok  = 1'b1;
      m_data_ok  = 1'b1;
      m_rdata    = 32'h0;

      // Reset: every handshake output stays low even with inputs active.
      #7;
      check_output("rst_m_req",        32'(m_req),        32'd0);
      check_output("rst_addr_ok",      32'({inst_addr_ok, data_addr_ok}), 32'd0);
      check_output("rst_data_ok",      32'({inst_data_ok, data_data_ok}), 32'd0);
      check_output("rst_resp_err",     32'(resp_err),     32'd0);
      @(negedge clk);
      inst_req  = 1'b0;
      data_req  = 1'b0;
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      resetn    = 1'b1;

      // Single instruction read, response three cycles after accept.
      inst_addr = 32'h1C00_0000;
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t1_addr_ok", 32'(inst_addr_ok), 32'd1);
      check_output("t1_m_addr",  m_addr, 32'h1C00_0000);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_output("t1_early_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0280_0000);
      check_output("t1_data_ok", 32'({inst_data_ok, data_data_ok}), 32'b10);
      check_output("t1_rdata",   inst_rdata, 32'h0280_0000);

      // Simultaneous requests: data wins, instruction follows, in-order responses.
      inst_addr  = 32'h1C00_0010;
      data_wr    = 1'b1;
      data_addr  = 32'h0000_1000;
      data_wstrb = 4'hF;
      data_wdata = 32'hCAFE_F00D;
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check_output("t2_first_ok", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
      check_output("t2_first_addr", m_addr, 32'h0000_1000);
      check_output("t2_first_wr", 32'(m_wr), 32'd1);
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t2_second_ok", 32'({inst_addr_ok, data_addr_ok}), 32'b10);
      check_output("t2_second_addr", m_addr, 32'h1C00_0010);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hD0D0_D0D0);
      check_output("t2_resp_d", 32'({inst_data_ok, data_data_ok}), 32'b01);
      check_output("t2_rdata_d", data_rdata, 32'hD0D0_D0D0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_2222);
      check_output("t2_resp_i", 32'({inst_data_ok, data_data_ok}), 32'b10);

      // Stalled data request must stay pinned while inst arrives later.
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(i >= 1, 1'b1, 1'b0, 1'b0, 32'h0);
         check_output("t3_hold_addr", m_addr, 32'h0000_1000);
         check_output("t3_hold_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      end
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check_output("t3_data_acc", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t3_inst_acc", 32'({inst_addr_ok, data_addr_ok}), 32'b10);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001);
      check_output("t3_resp_d", 32'({inst_data_ok, data_data_ok}), 32'b01);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0002);
      check_output("t3_resp_i", 32'({inst_data_ok, data_data_ok}), 32'b10);

      // Randomized traffic: a light-backpressure phase, then slow responses
      // so the outstanding limit and pointer wrap are exercised.
      @(negedge clk);
      m_data_ok = 1'b0;
      mon_en    = 1'b1;
      for (int i = 0; i < 1500; i++) run_random_cycle(50, 50);
      for (int i = 0; i < 1500; i++) run_random_cycle(60, 10);
      guard = 0;
      while ((mem_q.size() > 0 || inst_req || data_req) && guard < 500) begin
         run_random_cycle(0, 100);
         guard++;
      end
      check_output("drain_bound", 32'(guard < 500), 32'd1);
      check_output("drain_sb_empty", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      mon_en    = 1'b0;
      inst_done = 1'b0;
      data_done = 1'b0;

      // Response with nothing outstanding is dropped and flagged.
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h5555_5555);
      check_output("empty_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_output("empty_resp_err", 32'(resp_err), 32'd1);

      // Asynchronous reset while holding a stalled request with 3 in flight.
      inst_addr = 32'h1C00_0100;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      end
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      #2;
      check_output("pre_rst_m_req", 32'(m_req), 32'd1);
      check_output("pre_rst_count", 32'(dut.fifo_count), 32'd3);
      check_output("pre_rst_err",   32'(resp_err), 32'd1);
      resetn = 1'b0;
      #1;
      check_output("async_m_req", 32'(m_req), 32'd0);
      check_output("async_count", 32'(dut.fifo_count), 32'd0);
      check_output("async_err",   32'(resp_err), 32'd0);
      check_output("async_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
